// File: rtl/ripple_counter_pkg.sv
// Shared constants for the 4-bit ripple-style counter.
package ripple_counter_pkg;

  // Number of toggle stages, which is also the output width.
  localparam int CNT_W = 4;

  // Terminal value. The next count event after this value wraps to zero.
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

endpackage : ripple_counter_pkg

// File: rtl/ripple_counter_4bit_t_ff_stage.sv
// One toggle flip-flop stage. It is clocked on the falling edge and has a
// synchronous active-high clear.
module t_ff_stage (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic q
);

  // The power-up value keeps the output defined even when reset is released
  // before the first clock edge.
  logic q_r = 1'b0;

  // Clear has priority over toggle. Both take effect on the falling edge only.
  always_ff @(negedge clk) begin
    if (rst) begin
      q_r <= 1'b0;
    end else if (en) begin
      q_r <= ~q_r;
    end
  end

  assign q = q_r;

endmodule : t_ff_stage

// File: rtl/ripple_counter_4bit.sv
// 4-bit up-counter with ripple-counter behaviour, built as a synchronous
// chain of toggle stages that all update on the falling edge of cnt_i.
module ripple_counter_4bit
  import ripple_counter_pkg::*;
(
  input  logic cnt_i,
  input  logic rst_i,
  output logic A3_o,
  output logic A2_o,
  output logic A1_o,
  output logic A0_o
);

  logic [CNT_W-1:0] stage_q;
  logic [CNT_W-1:0] stage_en;

  // Stage 0 toggles on every event.
  assign stage_en[0] = 1'b1;

  // Stage k toggles when every lower stage is 1. This is the carry condition
  // that would ripple through a real toggle chain.
  for (genvar k = 1; k < CNT_W; k++) begin : g_en
    assign stage_en[k] = &stage_q[k-1:0];
  end

  // One toggle stage per count bit, all sharing the falling-edge clock.
  for (genvar k = 0; k < CNT_W; k++) begin : g_stage
    t_ff_stage u_stage (
      .clk (cnt_i),
      .rst (rst_i),
      .en  (stage_en[k]),
      .q   (stage_q[k])
    );
  end

  assign A0_o = stage_q[0];
  assign A1_o = stage_q[1];
  assign A2_o = stage_q[2];
  assign A3_o = stage_q[3];

endmodule : ripple_counter_4bit

// File: tb/tb_ripple_counter_4bit.sv
// Directed, scoreboard-based bench for ripple_counter_4bit.
module tb_ripple_counter_4bit;
  import ripple_counter_pkg::*;

  logic cnt_i;
  logic rst_i;
  logic A3_o, A2_o, A1_o, A0_o;

  int compared   = 0;
  int mismatched = 0;

  logic [CNT_W-1:0] model;
  logic [CNT_W-1:0] sb_q[$];

  ripple_counter_4bit dut (
    .cnt_i (cnt_i),
    .rst_i (rst_i),
    .A3_o  (A3_o),
    .A2_o  (A2_o),
    .A1_o  (A1_o),
    .A0_o  (A0_o)
  );

  wire [CNT_W-1:0] obs = {A3_o, A2_o, A1_o, A0_o};

  // 10 ns period. Low at t=0, so the first falling edge is at 10 ns.
  initial begin
    cnt_i = 1'b0;
    forever #5 cnt_i = ~cnt_i;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, observed=%b required=finish", obs);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [CNT_W-1:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Predict the result of the next falling edge, then compare the output
  // shortly after that edge. Compare again after the following rising edge,
  // which must not change the output.
  task automatic step(input string tag);
    logic [CNT_W-1:0] exp;
    if (rst_i)
      model = '0;
    else if (model == CNT_MAX)
      model = '0;
    else
      model = model + 1'b1;
    sb_q.push_back(model);
    @(negedge cnt_i);
    #2;
    exp = sb_q.pop_front();
    check(tag, exp);
    @(posedge cnt_i);
    #2;
    check({tag, "_rise"}, exp);
  endtask

  initial begin
    rst_i = 1'b1;
    model = '0;

    // Early release: reset drops before any falling edge has occurred.
    #4 rst_i = 1'b0;
    #3 check("powerup", 4'b0000);

    // Free count from 0001 up to 1111.
    for (int i = 1; i <= 15; i++) step("free");

    // Wrap-around.
    step("wrap0");
    step("wrap1");

    // Mid-count reset at 0110. The clear holds while reset stays high.
    for (int i = 2; i <= 6; i++) step("to6");
    check("at6", 4'b0110);
    rst_i = 1'b1;
    step("midrst");
    step("midrst_hold");
    rst_i = 1'b0;
    step("midrst_rel");

    // Reset at 1111 must clear, not wrap and then increment.
    for (int i = 2; i <= 15; i++) step("to15");
    check("at15", 4'b1111);
    rst_i = 1'b1;
    step("prio");
    rst_i = 1'b0;

    // Long run: 17 edges from a cleared state ends at 0001.
    for (int i = 1; i <= 17; i++) step("long");
    check("long_final", 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_ripple_counter_4bit
